// File: rtl/demux_scheduler_if.sv
// =============================================================================
//  Module   : demux_scheduler_if
//  Brief    : Input word stream and per-lane output bus of demux_scheduler.
//  Revision : 1.0  initial release
// =============================================================================
`default_nettype none

interface demux_scheduler_if #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4
) ();
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [N*DATA_WIDTH-1:0] out_data;
    logic [N-1:0]            out_valid;
    logic [N-1:0]            out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

`default_nettype wire

// File: rtl/demux_scheduler.sv
// =============================================================================
//  Module   : demux_scheduler
//  Brief    : Round-robin demultiplexer of one word stream onto N one-entry
//             lane buffers. Define DEMUX_SCHED_SKIP_EN to let the pointer skip
//             over full lanes instead of stalling on them.
//  Revision : 1.0  initial release
// =============================================================================
`default_nettype none

module demux_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4,
    parameter int SEL_WIDTH  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 flush,
    demux_scheduler_if.slave     bus,
    output logic [SEL_WIDTH-1:0] sel,
    output logic                 round_done,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                  round_done_q, round_done_d;
    logic [N-1:0]          lane_valid_q, lane_valid_d;
    logic [DATA_WIDTH-1:0] lane_data_q [N];
    logic [DATA_WIDTH-1:0] lane_data_d [N];

    logic [N-1:0]          lane_ready;
    logic [N-1:0]          lane_free;
    logic [SEL_WIDTH-1:0]  target;
    logic                  target_ok;
    logic                  in_ready;
    logic                  accept;
    logic                  target_last;

    // Lane-indexed bits on the bus are MSB-first, matching the out_data packing.
    for (genvar j = 0; j < N; j++) begin : g_lane
        assign lane_ready[j]         = bus.out_ready[N-1-j];
        assign bus.out_valid[N-1-j]  = lane_valid_q[j];
        assign bus.out_data[N*DATA_WIDTH-1-j*DATA_WIDTH -: DATA_WIDTH] = lane_data_q[j];
    end

    // A lane can take a word if empty or being emptied on this very edge.
    assign lane_free = ~lane_valid_q | lane_ready;

`ifdef DEMUX_SCHED_SKIP_EN
    always_comb begin : p_target
        int idx;
        target    = sel_q;
        target_ok = 1'b0;
        idx       = 0;
        // Walk offsets downwards so the nearest free lane from sel wins.
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(sel_q) + k) % N;
            if (lane_free[idx]) begin
                target    = SEL_WIDTH'(idx);
                target_ok = 1'b1;
            end
        end
    end
`else
    always_comb begin : p_target
        target    = sel_q;
        target_ok = lane_free[sel_q];
    end
`endif

    assign target_last = (target == SEL_WIDTH'(N - 1));
    assign in_ready    = rst_n && !flush && (state_q == ST_RUN) && target_ok;
    assign accept      = bus.in_valid && in_ready;

    always_comb begin : p_next
        state_d      = state_q;
        sel_d        = sel_q;
        round_done_d = 1'b0;
        lane_valid_d = lane_valid_q & ~lane_ready;
        for (int j = 0; j < N; j++) begin
            lane_data_d[j] = lane_data_q[j];
        end

        if (flush) begin
            lane_valid_d = '0;
            sel_d        = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!en) state_d = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (en)                      state_d = ST_RUN;
                    else if (lane_valid_q == '0) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase

            if (accept) begin
                lane_valid_d[target] = 1'b1;
                lane_data_d[target]  = bus.in_data;
                sel_d                = target_last ? '0 : target + SEL_WIDTH'(1);
                round_done_d         = target_last;
            end
        end
    end

    always_ff @(posedge clk) begin : p_regs
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            round_done_q <= 1'b0;
            lane_valid_q <= '0;
            for (int j = 0; j < N; j++) begin
                lane_data_q[j] <= '0;
            end
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            round_done_q <= round_done_d;
            lane_valid_q <= lane_valid_d;
            for (int j = 0; j < N; j++) begin
                lane_data_q[j] <= lane_data_d[j];
            end
        end
    end

    assign bus.in_ready = in_ready;
    assign sel          = sel_q;
    assign round_done   = round_done_q;
    assign state        = state_q;

endmodule

`default_nettype wire
